// File: rtl/pe_job_sequencer.sv
// pe_job_sequencer: job-level controller in front of the PE.
// Latches one job descriptor, holds the PE config, pulses pe_start, streams
// filter/IFmap/psum words into the PE write ports, then drains result words
// from the PE output buffer to a valid/ready sink and pulses done.
// Optional stall timeout: define PE_SEQ_TIMEOUT_EN.
module pe_job_sequencer #(
    parameter int IF_WIDTH       = 18,
    parameter int FILT_WIDTH     = 16,
    parameter int PSUM_WIDTH     = 32,
    parameter int FILT_ADDR_LEN  = 4,
    parameter int IF_ADDR_LEN    = 4,
    parameter int CNT_LEN        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [FILT_ADDR_LEN-1:0] job_filt_len,
    input  logic [IF_ADDR_LEN-1:0]   job_stride_len,
    input  logic [1:0]               job_mod,
    input  logic                     job_accumulate,
    input  logic [CNT_LEN-1:0]       job_n_filt,
    input  logic [CNT_LEN-1:0]       job_n_if,
    input  logic [CNT_LEN-1:0]       job_n_psum,
    input  logic [CNT_LEN-1:0]       job_n_out,
    input  logic                     filt_src_valid,
    output logic                     filt_src_ready,
    input  logic [FILT_WIDTH-1:0]    filt_src_data,
    input  logic                     if_src_valid,
    output logic                     if_src_ready,
    input  logic [IF_WIDTH-1:0]      if_src_data,
    input  logic                     psum_src_valid,
    output logic                     psum_src_ready,
    input  logic [PSUM_WIDTH-1:0]    psum_src_data,
    output logic [FILT_ADDR_LEN-1:0] pe_filt_len,
    output logic [IF_ADDR_LEN-1:0]   pe_stride_len,
    output logic [1:0]               pe_calc_mod,
    output logic                     pe_just_add_flag,
    output logic                     pe_start,
    output logic                     pe_filter_wen,
    output logic [FILT_WIDTH-1:0]    pe_filter_din,
    input  logic                     pe_filter_full,
    output logic                     pe_IF_wen,
    output logic [IF_WIDTH-1:0]      pe_IF_din,
    input  logic                     pe_IF_full,
    output logic                     pe_psum_buf_wen,
    output logic [PSUM_WIDTH-1:0]    pe_P_sum_buff_inp,
    input  logic                     pe_psum_full,
    output logic                     pe_outbuf_ren,
    input  logic [PSUM_WIDTH-1:0]    pe_outbuf_dout,
    input  logic                     pe_outbuf_empty,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PSUM_WIDTH-1:0]    out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    typedef enum logic [2:0] {IDLE, START, LOAD, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_LEN-1:0]   filt_rem, if_rem, psum_rem, out_rem;
    logic                 inflight;
    logic                 accept, load_done, drain_done, progress, timeout_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign accept = (state == IDLE) & job_valid;

    // Write strobes double as source ready: a word moves only when the PE has room
    assign pe_filter_wen   = (state == LOAD) & filt_src_valid & ~pe_filter_full & (filt_rem != '0);
    assign pe_IF_wen       = (state == LOAD) & if_src_valid & ~pe_IF_full & (if_rem != '0);
    assign pe_psum_buf_wen = (state == LOAD) & psum_src_valid & ~pe_psum_full & (psum_rem != '0);
    assign filt_src_ready  = pe_filter_wen;
    assign if_src_ready    = pe_IF_wen;
    assign psum_src_ready  = pe_psum_buf_wen;
    assign pe_filter_din     = filt_src_data;
    assign pe_IF_din         = if_src_data;
    assign pe_P_sum_buff_inp = psum_src_data;

    // Only one read in flight, and only when the output register is free next cycle
    assign pe_outbuf_ren = (state == DRAIN) & ~pe_outbuf_empty & ~inflight &
                           (out_rem != '0) & (~out_valid | out_ready);

    assign load_done  = (filt_rem == '0) & (if_rem == '0) & (psum_rem == '0);
    assign drain_done = (out_rem == '0) & ~inflight & (~out_valid | out_ready);
    assign progress   = pe_filter_wen | pe_IF_wen | pe_psum_buf_wen | pe_outbuf_ren;

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_cnt;

    assign timeout_hit = ((state == LOAD) | (state == DRAIN)) & ~progress &
                         (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    // Stall counter and sticky error flag, cleared by the next accepted job
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            error     <= 1'b0;
        end else begin
            if (accept)
                error <= 1'b0;
            else if (timeout_hit)
                error <= 1'b1;
            if (((state == LOAD) | (state == DRAIN)) & ~progress)
                stall_cnt <= stall_cnt + STALL_W'(1);
            else
                stall_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        pe_start  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_nxt = START;
            end
            START: begin
                pe_start  = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                if (timeout_hit)    state_nxt = DONE;
                else if (load_done) state_nxt = (out_rem != '0) ? DRAIN : DONE;
            end
            DRAIN: begin
                if (timeout_hit | drain_done) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job latch, per-channel counters and the single-entry output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pe_filt_len      <= '0;
            pe_stride_len    <= '0;
            pe_calc_mod      <= '0;
            pe_just_add_flag <= 1'b0;
            filt_rem         <= '0;
            if_rem           <= '0;
            psum_rem         <= '0;
            out_rem          <= '0;
            inflight         <= 1'b0;
            out_valid        <= 1'b0;
            out_data         <= '0;
        end else begin
            if (accept) begin
                pe_filt_len      <= job_filt_len;
                pe_stride_len    <= job_stride_len;
                pe_calc_mod      <= job_mod;
                pe_just_add_flag <= job_accumulate;
                filt_rem         <= job_n_filt;
                if_rem           <= job_n_if;
                psum_rem         <= job_n_psum;
                out_rem          <= job_n_out;
                inflight         <= 1'b0;
            end else begin
                if (pe_filter_wen)   filt_rem <= filt_rem - CNT_LEN'(1);
                if (pe_IF_wen)       if_rem   <= if_rem - CNT_LEN'(1);
                if (pe_psum_buf_wen) psum_rem <= psum_rem - CNT_LEN'(1);
                if (inflight) begin
                    out_data <= pe_outbuf_dout;
                    out_rem  <= out_rem - CNT_LEN'(1);
                    inflight <= 1'b0;
                end else if (pe_outbuf_ren) begin
                    inflight <= 1'b1;
                end
            end
            if (inflight)
                out_valid <= 1'b1;
            else if (out_valid & out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
